// File: rtl/psum_drain.sv
// psum_drain: read-side drain engine for the superblock partial-sum buffer.
// Streams num_words packed words starting at base_addr out of the buffer read
// port, splits each word into low-then-high half-words on a valid/ready stream,
// and limits read issue by credit so the unpack FIFO can never overflow.
// Optional feature macro: PSUM_DRAIN_CLR_EN (clear-on-read of each popped word).
module psum_drain #(
    parameter int WID_PSUM     = 36,
    parameter int WID_PSUMADDR = 9,
    parameter int RD_LAT       = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk_h,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WID_PSUMADDR-1:0]   base_addr,
    input  logic [WID_PSUMADDR:0]     num_words,
    output logic                      busy,
    output logic                      done,
    output logic                      psum_rd_en,
    output logic [WID_PSUMADDR-1:0]   psum_rd_addr,
    input  logic [2*WID_PSUM-1:0]     psum_rd_data,
    output logic [WID_PSUM-1:0]       out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      psum_clr_en,
    output logic [WID_PSUMADDR-1:0]   psum_clr_addr
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                  state_reg;
    logic [WID_PSUMADDR-1:0] base_reg;
    logic [WID_PSUMADDR:0]   num_reg;
    logic [WID_PSUMADDR:0]   issued_reg;
    logic [WID_PSUMADDR:0]   popped_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [RD_LAT-1:0]       dly_reg;
    logic [CNT_W-1:0]        inflight_reg;
    logic [CNT_W-1:0]        fifo_count_reg;
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic                    half_reg;
    logic [2*WID_PSUM-1:0]   fifo_mem [FIFO_DEPTH];

    logic rd_fire;
    logic push;
    logic hs;
    logic pop;
    logic drain_end;
    logic [2*WID_PSUM-1:0] head_word;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A read may only go out if its data is guaranteed a FIFO slot on return.
    assign rd_fire   = (state_reg == RUN) && (issued_reg < num_reg) &&
                       (({1'b0, inflight_reg} + {1'b0, fifo_count_reg}) < CREDIT_MAX);
    assign push      = dly_reg[RD_LAT-1];
    assign out_valid = (fifo_count_reg != '0);
    assign hs        = out_valid && out_ready;
    assign pop       = hs && half_reg;
    assign head_word = fifo_mem[rd_ptr_reg];
    assign out_data  = !out_valid ? '0 :
                       (half_reg ? head_word[2*WID_PSUM-1:WID_PSUM] : head_word[WID_PSUM-1:0]);
    assign out_last  = out_valid && half_reg && ((popped_reg + 1'b1) == num_reg);
    assign drain_end = ((pop && out_last) || (popped_reg == num_reg)) && (inflight_reg == '0);

    assign psum_rd_en   = rd_fire;
    assign psum_rd_addr = base_reg + issued_reg[WID_PSUMADDR-1:0];
    assign busy         = busy_reg;
    assign done         = done_reg;

    // Control FSM: latch the drain request, count issued/popped words, signal completion.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            base_reg   <= '0;
            num_reg    <= '0;
            issued_reg <= '0;
            popped_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (rd_fire) issued_reg <= issued_reg + 1'b1;
            if (pop)     popped_reg <= popped_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        base_reg   <= base_addr;
                        num_reg    <= num_words;
                        issued_reg <= '0;
                        popped_reg <= '0;
                        if (num_words == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issued_reg == num_reg) state_reg <= FLUSH;
                end
                FLUSH: begin
                    if (drain_end) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Read-latency shadow: marks which cycles carry returning buffer data.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            dly_reg      <= '0;
            inflight_reg <= '0;
        end else begin
            dly_reg[0] <= rd_fire;
            for (int i = 1; i < RD_LAT; i++) dly_reg[i] <= dly_reg[i-1];
            inflight_reg <= inflight_reg + CNT_W'(rd_fire) - CNT_W'(push);
        end
    end

    // Unpack FIFO bookkeeping; the half-select advances on every handshake.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
            half_reg       <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            fifo_count_reg <= fifo_count_reg + CNT_W'(push) - CNT_W'(pop);
            if (hs) half_reg <= ~half_reg;
        end
    end

    // FIFO storage; contents are qualified by the count, so no reset is needed.
    always_ff @(posedge clk_h) begin
        if (push) fifo_mem[wr_ptr_reg] <= psum_rd_data;
    end

    a_no_overflow: assert property (@(posedge clk_h) disable iff (!rst_n)
        !(push && !pop && (fifo_count_reg == CNT_FULL)));

`ifdef PSUM_DRAIN_CLR_EN
    logic [WID_PSUMADDR-1:0] clr_mem [FIFO_DEPTH];
    logic [WID_PSUMADDR-1:0] push_addr_reg;
    logic [WID_PSUMADDR-1:0] clr_addr_reg;
    logic                    clr_en_reg;

    // Address of the next returning word; returns arrive in issue order.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n)                          push_addr_reg <= '0;
        else if ((state_reg == IDLE) && start) push_addr_reg <= base_addr;
        else if (push)                       push_addr_reg <= push_addr_reg + 1'b1;
    end

    // Word addresses travel through the FIFO next to their data.
    always_ff @(posedge clk_h) begin
        if (push) clr_mem[wr_ptr_reg] <= push_addr_reg;
    end

    // Issue one clear write the cycle after each word is fully consumed.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            clr_en_reg   <= 1'b0;
            clr_addr_reg <= '0;
        end else begin
            clr_en_reg <= pop;
            if (pop) clr_addr_reg <= clr_mem[rd_ptr_reg];
        end
    end

    assign psum_clr_en   = clr_en_reg;
    assign psum_clr_addr = clr_addr_reg;
`else
    assign psum_clr_en   = 1'b0;
    assign psum_clr_addr = '0;
`endif

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: randomized bench for psum_drain with a queue-based reference
// model of the drained half-word stream, read addresses, credits and clears.
module tb_psum_drain;
    localparam int W     = 36;
    localparam int AW    = 9;
    localparam int DEPTH = 4;

    logic            clk_h;
    logic            rst_n;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [AW:0]     num_words;
    logic            busy;
    logic            done;
    logic            psum_rd_en;
    logic [AW-1:0]   psum_rd_addr;
    logic [2*W-1:0]  psum_rd_data;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            psum_clr_en;
    logic [AW-1:0]   psum_clr_addr;

    psum_drain dut (
        .clk_h(clk_h), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done), .psum_rd_en(psum_rd_en),
        .psum_rd_addr(psum_rd_addr), .psum_rd_data(psum_rd_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .psum_clr_en(psum_clr_en), .psum_clr_addr(psum_clr_addr)
    );

    initial begin
        clk_h = 1'b0;
        forever #5 clk_h = ~clk_h;
    end

    // Buffer model: two-stage read pipeline
    logic [2*W-1:0] mem_model [512];
    logic [2*W-1:0] rd_s1, rd_s2;
    always @(posedge clk_h) begin
        if (psum_rd_en) rd_s1 <= mem_model[psum_rd_addr];
        rd_s2 <= rd_s1;
    end
    assign psum_rd_data = rd_s2;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int   nc = 0;
    bit   active = 0, done_next = 0, first_pending = 0, clr_pend = 0;
    bit   dn_new, clr_pend_new;
    int   m_base = 0, m_n = 0, issued = 0, hs_cnt = 0, start_nc = 0, done_cnt = 0;
    int   clr_exp = 0;
    int   last_val = -1;
    logic [2*W-1:0] w;
    logic [W:0]     exp_q [$];
    logic [W-1:0]   got_q [$];
    int             addr_q [$];
    int             clr_q [$];

    // Ready driver: 0 = always, 1 = one cycle in three, 2 = random
    int mode = 0;
    int rcnt = 0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk_h);
            #1;
            rcnt++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (rcnt % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: checks every DUT output against the model each cycle
    always @(negedge clk_h) begin
        nc++;
        if (!rst_n) begin
            check("reset_outputs", {busy, done, psum_rd_en, out_valid, out_last, psum_clr_en,
                                    out_data, psum_clr_addr, psum_rd_addr}, '0);
            active = 0; done_next = 0; first_pending = 0; clr_pend = 0;
            issued = 0; hs_cnt = 0;
            exp_q.delete();
        end else begin
            dn_new = 0;
            clr_pend_new = 0;
            check("done", done, done_next);
            check("busy", busy, active && !done_next);
            if (psum_rd_en) begin
                check("rd_allowed", {active, issued < m_n}, 2'b11);
                check("rd_addr", psum_rd_addr, (m_base + issued) % 512);
                addr_q.push_back(int'(psum_rd_addr));
                issued++;
            end
            check("credit", (issued - hs_cnt / 2) <= DEPTH, 1);
`ifdef PSUM_DRAIN_CLR_EN
            check("clr_en", psum_clr_en, clr_pend);
            if (clr_pend) begin
                check("clr_addr", psum_clr_addr, clr_exp);
                clr_q.push_back(int'(psum_clr_addr));
            end
`else
            check("clr_tied", {psum_clr_en, psum_clr_addr}, '0);
`endif
            if (out_valid) begin
                if (first_pending) begin
                    check("latency", nc - start_nc, 4);
                    first_pending = 0;
                end
                if (exp_q.size() == 0) begin
                    check("spurious_valid", out_valid, 0);
                end else begin
                    check("out_data", out_data, exp_q[0][W-1:0]);
                    check("out_last", out_last, exp_q[0][W]);
                    if (out_ready) begin
                        got_q.push_back(out_data);
                        if (out_last) begin
                            dn_new = 1;
                            last_val = int'(out_data);
                        end
                        if (hs_cnt % 2 == 1) begin
                            clr_pend_new = 1;
                            clr_exp = (m_base + hs_cnt / 2) % 512;
                        end
                        hs_cnt++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (done) done_cnt++;
            if (done_next) active = 0;
            if (start && !active) begin
                m_base = int'(base_addr);
                m_n    = int'(num_words);
                issued = 0;
                hs_cnt = 0;
                exp_q.delete();
                for (int k = 0; k < m_n; k++) begin
                    w = mem_model[(m_base + k) % 512];
                    exp_q.push_back({1'b0, w[W-1:0]});
                    exp_q.push_back({(k == m_n - 1), w[2*W-1:W]});
                end
                if (m_n == 0) dn_new = 1;
                else begin
                    active = 1;
                    first_pending = 1;
                    start_nc = nc;
                end
            end
            done_next = dn_new;
            clr_pend  = clr_pend_new;
        end
    end

    task automatic start_pulse(input int b, input int n);
        @(posedge clk_h);
        #1;
        base_addr = AW'(b);
        num_words = (AW+1)'(n);
        start = 1'b1;
        @(posedge clk_h);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((active || done_next) && i < 400) begin
            @(posedge clk_h);
            i++;
        end
        check("drain_timeout", active || done_next, 0);
        @(posedge clk_h);
        #1;
    endtask

    task automatic do_drain(input int b, input int n);
        start_pulse(b, n);
        wait_idle();
    endtask

    int d0, a0, n_rand;
    int exp3 [4] = '{510, 511, 0, 1};

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        for (int k = 0; k < 512; k++) mem_model[k] = {36'(2 * k + 1), 36'(2 * k)};
        repeat (3) @(posedge clk_h);
        #1 rst_n = 1'b1;

        // Basic drain: values 0..7, last on 7, one done
        got_q.delete(); d0 = done_cnt;
        do_drain(0, 4);
        check("t1_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++) check("t1_value", got_q[i], i);
        check("t1_last", last_val, 7);
        check("t1_done_cnt", done_cnt - d0, 1);

        // Zero-length drain
        d0 = done_cnt; a0 = addr_q.size();
        do_drain(0, 0);
        check("t2_done_cnt", done_cnt - d0, 1);
        check("t2_no_reads", addr_q.size() - a0, 0);

        // Address wrap
        addr_q.delete();
        do_drain(510, 4);
        check("t3_count", addr_q.size(), 4);
        for (int i = 0; i < 4; i++) check("t3_addr", addr_q[i], exp3[i]);

        // Back-pressure, ready one cycle in three
        mode = 1; got_q.delete();
        do_drain(0, 8);
        check("t4_count", got_q.size(), 16);
        for (int i = 0; i < 16; i++) check("t4_value", got_q[i], i);

        // Reset mid-drain, then a fresh short drain
        mode = 0;
        start_pulse(0, 8);
        for (int i = 0; i < 100 && hs_cnt < 3; i++) @(posedge clk_h);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk_h);
        #1 rst_n = 1'b1;
        got_q.delete();
        do_drain(20, 2);
        check("t5_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) check("t5_value", got_q[i], 40 + i);

`ifdef PSUM_DRAIN_CLR_EN
        clr_q.delete();
        do_drain(5, 3);
        check("t6_clr_count", clr_q.size(), 3);
        for (int i = 0; i < 3; i++) check("t6_clr_addr", clr_q[i], 5 + i);
`endif

        // Randomized drains, some with an ignored start while busy
        for (int k = 0; k < 512; k++) mem_model[k] = {8'($urandom), 32'($urandom), 32'($urandom)};
        for (int i = 0; i < 25; i++) begin
            mode = $urandom_range(0, 2);
            n_rand = $urandom_range(1, 24);
            got_q.delete();
            start_pulse($urandom_range(0, 511), n_rand);
            if (i % 3 == 0) begin
                @(posedge clk_h);
                #1;
                base_addr = AW'($urandom); num_words = 10'd5; start = 1'b1;
                @(posedge clk_h);
                #1 start = 1'b0;
            end
            wait_idle();
            check("rand_count", got_q.size(), 2 * n_rand);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
